// File: rtl/segdac_switch_driver.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | segdac_switch_driver: level -> thermometer switch driver for segmented DACs, with DWA,  |
// | ramp test pattern, blanking and per-channel bias-select registers.   Rev 1.0            |
// +------------------------------------------------------------------------------------------+
module segdac_switch_driver #(
    parameter int                NUM_CH   = 3,
    parameter int                NSEG     = 4,
    parameter int                NSW      = 3,
    parameter int                LEVEL_W  = 4,
    parameter int                BIAS_W   = 3,
    parameter logic [BIAS_W-1:0] BIAS_RST = 3'b111,
    parameter int                RAMP_DIV = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena_i,
    input  logic [1:0]                  mode_i,
    input  logic [NUM_CH*LEVEL_W-1:0]   code_in_i,
    input  logic                        code_valid_i,
    input  logic                        blank_i,
    input  logic [NUM_CH*BIAS_W-1:0]    bias_in_i,
    input  logic                        bias_load_i,
    output logic [NUM_CH*NSEG*NSW-1:0]  sw_out_o,
    output logic [NUM_CH*BIAS_W-1:0]    bias_out_o,
    output logic [NUM_CH-1:0]           sat_o
);

    localparam int                 SW_W     = NSEG * NSW;
    localparam int                 DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(SW_W);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RAMP_DIV - 1);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_DWA    = 2'b01;
    localparam logic [1:0] MODE_RAMP   = 2'b10;

    logic [1:0]                mode_q, mode_d;
    logic [NUM_CH*LEVEL_W-1:0] lvl_q,  lvl_d;
    logic [NUM_CH*LEVEL_W-1:0] ptr_q,  ptr_d;
    logic [DIV_W-1:0]          div_q,  div_d;
    logic [LEVEL_W-1:0]        ramp_q, ramp_d;
    logic [NUM_CH*SW_W-1:0]    sw_q,   sw_d;
    logic [NUM_CH*BIAS_W-1:0]  bias_q, bias_d;
    logic [NUM_CH-1:0]         sat_q,  sat_d;

    function automatic logic [SW_W-1:0] therm(input logic [LEVEL_W-1:0] lvl);
        logic [SW_W-1:0] t;
        for (int i = 0; i < SW_W; i++) t[i] = (LEVEL_W'(i) < lvl);
        return t;
    endfunction

    // Switch i is on when its distance past the pointer (mod SW_W) is below the level.
    function automatic logic [SW_W-1:0] rotate(input logic [LEVEL_W-1:0] lvl,
                                               input logic [LEVEL_W-1:0] ptr);
        logic [SW_W-1:0]  t;
        logic [LEVEL_W:0] d;
        for (int i = 0; i < SW_W; i++) begin
            if (LEVEL_W'(i) >= ptr) d = (LEVEL_W+1)'(i) - {1'b0, ptr};
            else                    d = (LEVEL_W+1)'(i + SW_W) - {1'b0, ptr};
            t[i] = (d < {1'b0, lvl});
        end
        return t;
    endfunction

    function automatic logic [LEVEL_W-1:0] wrap_add(input logic [LEVEL_W-1:0] ptr,
                                                    input logic [LEVEL_W-1:0] lvl);
        logic [LEVEL_W:0] s;
        s = {1'b0, ptr} + {1'b0, lvl};
        if (s >= (LEVEL_W+1)'(SW_W)) s = s - (LEVEL_W+1)'(SW_W);
        return s[LEVEL_W-1:0];
    endfunction

    always_comb begin
        logic [LEVEL_W-1:0] code;
        logic [LEVEL_W-1:0] lvl;
        logic [LEVEL_W-1:0] r_next;
        code   = '0;
        lvl    = '0;
        r_next = ramp_q;
        mode_d = mode_q;
        lvl_d  = lvl_q;
        ptr_d  = ptr_q;
        div_d  = div_q;
        ramp_d = ramp_q;
        sw_d   = sw_q;
        bias_d = bias_q;
        sat_d  = sat_q;
        if (ena_i) begin
            mode_d = mode_i;
            if (bias_load_i) bias_d = bias_in_i;
            if (mode_i != mode_q) begin
                ptr_d  = '0;
                div_d  = '0;
                ramp_d = '0;
                sat_d  = '0;
                sw_d   = '0;
            end else begin
                case (mode_q)
                    MODE_DIRECT, MODE_DWA: begin
                        if (blank_i) sw_d = '0;
                        if (code_valid_i) begin
                            for (int ch = 0; ch < NUM_CH; ch++) begin
                                code = code_in_i[ch*LEVEL_W +: LEVEL_W];
                                lvl  = (code > LVL_MAX) ? LVL_MAX : code;
                                lvl_d[ch*LEVEL_W +: LEVEL_W] = lvl;
                                if (code > LVL_MAX) sat_d[ch] = 1'b1;
                                // Blanked strobes still capture the level but leave the pointer.
                                if (!blank_i) begin
                                    if (mode_q == MODE_DIRECT) begin
                                        sw_d[ch*SW_W +: SW_W] = therm(lvl);
                                    end else begin
                                        sw_d[ch*SW_W +: SW_W] =
                                            rotate(lvl, ptr_q[ch*LEVEL_W +: LEVEL_W]);
                                        ptr_d[ch*LEVEL_W +: LEVEL_W] =
                                            wrap_add(ptr_q[ch*LEVEL_W +: LEVEL_W], lvl);
                                    end
                                end
                            end
                        end
                    end
                    MODE_RAMP: begin
                        if (div_q == DIV_LAST) begin
                            div_d  = '0;
                            r_next = (ramp_q == LVL_MAX) ? '0 : ramp_q + 1'b1;
                            ramp_d = r_next;
                            sw_d   = {NUM_CH{therm(r_next)}};
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                        if (blank_i) sw_d = '0;
                    end
                    default: sw_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_DIRECT;
            lvl_q  <= '0;
            ptr_q  <= '0;
            div_q  <= '0;
            ramp_q <= '0;
            sw_q   <= '0;
            bias_q <= {NUM_CH{BIAS_RST}};
            sat_q  <= '0;
        end else begin
            mode_q <= mode_d;
            lvl_q  <= lvl_d;
            ptr_q  <= ptr_d;
            div_q  <= div_d;
            ramp_q <= ramp_d;
            sw_q   <= sw_d;
            bias_q <= bias_d;
            sat_q  <= sat_d;
        end
    end

    assign sw_out_o   = sw_q;
    assign bias_out_o = bias_q;
    assign sat_o      = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_segdac_switch_driver.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | tb_segdac_switch_driver: directed self-checking bench for segdac_switch_driver. Rev 1.0 |
// +------------------------------------------------------------------------------------------+
module tb_segdac_switch_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [1:0]  mode;
    logic [11:0] code_in;
    logic        code_valid;
    logic        blank;
    logic [8:0]  bias_in;
    logic        bias_load;
    logic [35:0] sw_out;
    logic [8:0]  bias_out;
    logic [2:0]  sat;

    int checks   = 0;
    int failures = 0;

    segdac_switch_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena_i        (ena),
        .mode_i       (mode),
        .code_in_i    (code_in),
        .code_valid_i (code_valid),
        .blank_i      (blank),
        .bias_in_i    (bias_in),
        .bias_load_i  (bias_load),
        .sw_out_o     (sw_out),
        .bias_out_o   (bias_out),
        .sat_o        (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] th(input int r);
        logic [11:0] one;
        one = 12'h1;
        return (one << r) - 12'h1;
    endfunction

    initial begin
        logic [11:0] t;
        rst_n = 1'b0; ena = 1'b1; mode = 2'b00; code_in = '0; code_valid = 1'b0;
        blank = 1'b0; bias_in = '0; bias_load = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        chk("reset_sw",   sw_out,   36'h0);
        chk("reset_bias", bias_out, 9'h1FF);
        chk("reset_sat",  sat,      3'b000);

        // Direct mode with a saturating channel
        code_in = {4'd15, 4'd12, 4'd5}; code_valid = 1'b1;
        tick();
        chk("direct_sw",  sw_out, {12'hFFF, 12'hFFF, 12'h01F});
        chk("direct_sat", sat,    3'b100);
        code_valid = 1'b0; code_in = {4'd1, 4'd1, 4'd1};
        tick();
        chk("direct_hold", sw_out, {12'hFFF, 12'hFFF, 12'h01F});

        bias_in = 9'h0A5; bias_load = 1'b1;
        tick();
        chk("bias_load", bias_out, 9'h0A5);
        bias_load = 1'b0;

        // ena=0 freezes everything
        ena = 1'b0; code_valid = 1'b1; code_in = {4'd0, 4'd0, 4'd3};
        bias_in = 9'h1C3; bias_load = 1'b1;
        tick();
        chk("ena0_sw",   sw_out,   {12'hFFF, 12'hFFF, 12'h01F});
        chk("ena0_bias", bias_out, 9'h0A5);
        chk("ena0_sat",  sat,      3'b100);
        ena = 1'b1; bias_load = 1'b0;

        // Mode change drops the strobe
        mode = 2'b01; code_in = {4'd15, 4'd3, 4'd3}; code_valid = 1'b1;
        tick();
        chk("modechg_sw",  sw_out, 36'h0);
        chk("modechg_sat", sat,    3'b000);

        // DWA rotation
        code_in = {4'd12, 4'd0, 4'd5};
        tick();
        chk("dwa_1", sw_out, {12'hFFF, 12'h000, 12'h01F});
        tick();
        chk("dwa_2", sw_out, {12'hFFF, 12'h000, 12'h3E0});
        tick();
        chk("dwa_3", sw_out, {12'hFFF, 12'h000, 12'hC07});
        code_in = {4'd0, 4'd0, 4'd1};
        tick();
        chk("dwa_ptr3", sw_out, {12'h000, 12'h000, 12'h008});

        // Blank with strobe: captured, sat updates, pointer stays at 4
        blank = 1'b1; code_in = {4'd0, 4'd13, 4'd4};
        tick();
        chk("blank_sw",  sw_out, 36'h0);
        chk("blank_sat", sat,    3'b010);
        blank = 1'b0; code_valid = 1'b0;
        tick();
        chk("blank_fall_hold", sw_out, 36'h0);
        code_valid = 1'b1; code_in = {4'd0, 4'd0, 4'd4};
        tick();
        chk("blank_after", sw_out, {12'h000, 12'h000, 12'h0F0});

        // Off mode
        mode = 2'b11;
        tick();
        chk("off_chg_sat", sat, 3'b000);
        code_in = {4'd5, 4'd5, 4'd5};
        tick();
        chk("off_sw", sw_out, 36'h0);

        // Ramp
        code_valid = 1'b0; mode = 2'b10;
        tick();
        chk("ramp_start", sw_out, 36'h0);
        for (int k = 1; k <= 13; k++) begin
            tick(); tick(); tick();
            t = th(k - 1);
            chk("ramp_mid", sw_out, {t, t, t});
            tick();
            t = th(k % 13);
            chk("ramp_step", sw_out, {t, t, t});
        end
        blank = 1'b1;
        tick(); tick(); tick(); tick();
        chk("ramp_blank", sw_out, 36'h0);
        blank = 1'b0;
        tick(); tick(); tick();
        chk("ramp_blank_hold", sw_out, 36'h0);
        tick();
        chk("ramp_after_blank", sw_out, {12'h003, 12'h003, 12'h003});

        // Async reset mid-run
        mode = 2'b00;
        tick();
        code_valid = 1'b1; code_in = {4'd0, 4'd0, 4'd14};
        tick();
        chk("pre_reset_sat", sat, 3'b001);
        code_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_sw",   sw_out,   36'h0);
        chk("async_bias", bias_out, 9'h1FF);
        chk("async_sat",  sat,      3'b000);
        #2 rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
